oc8051_xram_responder: RTL

Synthesizable Wishbone-classic slave that answers the oc8051 core's external data bus (the wbd_* master port) with a byte-wide RAM. It replaces the constant-zero data stimulus used in simulation and formal harnesses so MOVX reads and writes see real, stateful memory. The block sits beside the core inside the FV/sim top and is driven only by the core's data-bus outputs.

---
 rtl/oc8051_xram_responder_if.sv | 31 +++
 rtl/oc8051_xram_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/oc8051_xram_responder_if.sv
// oc8051_xram_responder_if
//   Wishbone-classic data bus between the oc8051 core (master) and the
//   external RAM responder (slave). Signal names keep the core's point of
//   view: *_o are driven by the core, *_i are returned to it.
//
//   wbd_adr_o  [15:0]  byte address from the core
//   wbd_dat_o  [7:0]   write data from the core
//   wbd_we_o           1 = write, 0 = read
//   wbd_stb_o          strobe
//   wbd_cyc_o          bus cycle valid
//   wbd_dat_i  [7:0]   read data to the core
//   wbd_ack_i          one-cycle transfer acknowledge
interface oc8051_xram_responder_if;
    logic [15:0] wbd_adr_o;
    logic [7:0]  wbd_dat_o;
    logic        wbd_we_o;
    logic        wbd_stb_o;
    logic        wbd_cyc_o;
    logic [7:0]  wbd_dat_i;
    logic        wbd_ack_i;

    modport master (
        output wbd_adr_o, wbd_dat_o, wbd_we_o, wbd_stb_o, wbd_cyc_o,
        input  wbd_dat_i, wbd_ack_i
    );

    modport slave (
        input  wbd_adr_o, wbd_dat_o, wbd_we_o, wbd_stb_o, wbd_cyc_o,
        output wbd_dat_i, wbd_ack_i
    );
endinterface

// File: rtl/oc8051_xram_responder.sv
// oc8051_xram_responder
//   Byte-wide RAM answering the oc8051 external data bus so MOVX reads and
//   writes see real, stateful memory. After reset the whole array is cleared
//   one byte per cycle; init_done rises when the clear is complete and only
//   then are requests served. Each transfer is acked after WAIT_STATES extra
//   cycles; dropping the request during the wait aborts it silently.
//   Addresses with bits above ADDR_W set are out of range: reads return
//   OOR_DATA, writes are discarded, both are still acked.
//
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   bus        slave side of the Wishbone data bus
//   init_done  high once the post-reset memory clear has finished
module oc8051_xram_responder #(
    parameter int         ADDR_W      = 8,
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] OOR_DATA    = 8'hFF
) (
    input  logic                          clk,
    input  logic                          rst,
    oc8051_xram_responder_if.slave        bus,
    output logic                          init_done
);
    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WS    = WAIT_STATES[3:0];

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [3:0]        wait_cnt;
    logic [15:0]       adr_q;
    logic [7:0]        dat_q;
    logic              we_q;

    logic [7:0]        mem [DEPTH];

    logic              req;
    logic              enter_ack;
    logic [15:0]       cur_adr;
    logic [7:0]        cur_dat;
    logic              cur_we;
    logic              cur_in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    assign req = bus.wbd_stb_o & bus.wbd_cyc_o;

    // NOTE: every signal gets a default at the top of the block so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        // With zero wait states the transfer completes on the same edge that
        // samples it, so the live bus fields stand in for the latched copies.
        if (state == ST_IDLE) begin
            cur_adr = bus.wbd_adr_o;
            cur_dat = bus.wbd_dat_o;
            cur_we  = bus.wbd_we_o;
        end else begin
            cur_adr = adr_q;
            cur_dat = dat_q;
            cur_we  = we_q;
        end
        cur_in_range = (cur_adr >> ADDR_W) == 16'h0;

        enter_ack = 1'b0;
        if (state == ST_IDLE && req && WS == 4'd0) enter_ack = 1'b1;
        if (state == ST_WAIT && req && wait_cnt == 4'd1) enter_ack = 1'b1;

        mem_we    = 1'b0;
        mem_waddr = cur_adr[ADDR_W-1:0];
        mem_wdata = cur_dat;
        if (!rst) begin
            if (state == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = 8'h00;
            end else if (enter_ack && cur_we && cur_in_range) begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: the array has no reset branch; it is cleared by the INIT walk,
    // which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_INIT;
            clr_ptr       <= '0;
            wait_cnt      <= 4'd0;
            init_done     <= 1'b0;
            adr_q         <= 16'h0000;
            dat_q         <= 8'h00;
            we_q          <= 1'b0;
            bus.wbd_ack_i <= 1'b0;
            bus.wbd_dat_i <= 8'h00;
        end else begin
            bus.wbd_ack_i <= enter_ack;
            if (enter_ack && !cur_we) begin
                bus.wbd_dat_i <= cur_in_range ? mem[cur_adr[ADDR_W-1:0]] : OOR_DATA;
            end

            case (state)
                ST_INIT: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == {ADDR_W{1'b1}}) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req) begin
                        adr_q    <= bus.wbd_adr_o;
                        dat_q    <= bus.wbd_dat_o;
                        we_q     <= bus.wbd_we_o;
                        wait_cnt <= WS;
                        state    <= (WS == 4'd0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        // core withdrew the request: abort without ack or write
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) state <= ST_ACK;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
